bram_rd_streamer: RTL and testbench

//  Read-side client for a single-clock BRAM port with 1- or 2-cycle read latency.

---
 rtl/bram_rd_streamer.sv | 174 +++++++++++++++++
 tb/tb_bram_rd_streamer.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_rd_streamer.sv
// Streams a (start address, length) BRAM read command out as a valid/ready burst.
// Ports: clka/rst, cmd_* command handshake, bram_* read port, m_* stream out, busy.
module bram_rd_streamer #(
  parameter int RAM_WIDTH  = 18,
  parameter int RAM_DEPTH  = 1024,
  parameter int RD_LATENCY = 2,
  localparam int AW = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1
) (
  input  logic                 clka,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [AW-1:0]        cmd_addr,
  input  logic [AW:0]          cmd_len,
  output logic                 bram_en,
  output logic                 bram_we,
  output logic                 bram_regce,
  output logic [AW-1:0]        bram_addr,
  input  logic [RAM_WIDTH-1:0] bram_dout,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [RAM_WIDTH-1:0] m_data,
  output logic                 m_last,
  output logic                 busy
);

  localparam int D  = RD_LATENCY + 1;
  localparam int PW = (D > 1) ? $clog2(D) : 1;
  localparam int CW = $clog2(D + 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN
  } state_t;

  state_t state_q, state_d;

  logic [AW-1:0] addr_q, addr_d;
  logic [AW-1:0] hold_q, hold_d;
  logic [AW:0]   rem_q, rem_d;

  logic [RD_LATENCY-1:0] vld_q, vld_d;
  logic [RD_LATENCY-1:0] lst_q, lst_d;
  logic                  regce_q;

  logic [RAM_WIDTH:0] mem_q [D];
  logic [PW-1:0]      wr_q, wr_d;
  logic [PW-1:0]      rd_q, rd_d;
  logic [CW-1:0]      cnt_q, cnt_d;

  logic               push, push_last;
  logic               have, pop, fpop, store;
  logic               issue, last_rd;
  logic [CW-1:0]      inflight;
  logic [RAM_WIDTH:0] head;
  int                 occ;

  always_comb begin
    push      = vld_q[RD_LATENCY-1];
    push_last = lst_q[RD_LATENCY-1];
    have      = (cnt_q != '0);
    head      = mem_q[rd_q];

    // Empty FIFO falls through to the returning BRAM word.
    m_valid = have | push;
    m_data  = have ? head[RAM_WIDTH-1:0]
                   : (push ? bram_dout : '0);
    m_last  = have ? head[RAM_WIDTH] : (push & push_last);

    pop   = m_valid & m_ready;
    fpop  = pop & have;
    store = push & (have | ~pop);

    inflight = '0;
    for (int i = 0; i < RD_LATENCY; i++) begin
      inflight = inflight + CW'(vld_q[i]);
    end

    // Occupancy after this cycle's pop; a returning word just
    // moves from in-flight to FIFO, so it does not change the sum.
    occ   = 32'(cnt_q) + 32'(inflight) - 32'(pop);
    issue = (state_q == ISSUE) && (rem_q != '0) && (occ < D);
    last_rd = (rem_q == (AW+1)'(1));
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    hold_d  = hold_q;
    rem_d   = rem_q;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          addr_d = cmd_addr;
          rem_d  = cmd_len;
          if (cmd_len != '0) state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (issue) begin
          hold_d = addr_q;
          addr_d = (addr_q == AW'(RAM_DEPTH - 1))
                   ? '0 : addr_q + 1'b1;
          rem_d  = rem_q - 1'b1;
          if (last_rd) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && m_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    vld_d    = '0;
    lst_d    = '0;
    vld_d[0] = issue;
    lst_d[0] = issue & last_rd;
    for (int i = 1; i < RD_LATENCY; i++) begin
      vld_d[i] = vld_q[i-1];
      lst_d[i] = lst_q[i-1];
    end
  end

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q + CW'(store) - CW'(fpop);
    if (store) begin
      wr_d = (wr_q == PW'(D - 1)) ? '0 : wr_q + 1'b1;
    end
    if (fpop) begin
      rd_d = (rd_q == PW'(D - 1)) ? '0 : rd_q + 1'b1;
    end
  end

  always_ff @(posedge clka or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      hold_q  <= '0;
      rem_q   <= '0;
      vld_q   <= '0;
      lst_q   <= '0;
      regce_q <= 1'b0;
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      for (int i = 0; i < D; i++) mem_q[i] <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      hold_q  <= hold_d;
      rem_q   <= rem_d;
      vld_q   <= vld_d;
      lst_q   <= lst_d;
      regce_q <= issue;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      if (store) mem_q[wr_q] <= {push_last, bram_dout};
    end
  end

  assign bram_en    = issue;
  assign bram_we    = 1'b0;
  assign bram_regce = regce_q;
  assign bram_addr  = issue ? addr_q : hold_q;
  assign cmd_ready  = (state_q == IDLE);
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_bram_rd_streamer.sv
// Bench for bram_rd_streamer: queue reference model, vector table,
// reset/empty/latency-1 sequences and random backpressure.
module tb_bram_rd_streamer;

  localparam int W   = 18;
  localparam int DEP = 1024;
  localparam int AW  = 10;
  localparam int D2  = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic          cmd_valid2 = 1'b0;
  logic          cmd_ready2;
  logic [AW-1:0] cmd_addr2 = '0;
  logic [AW:0]   cmd_len2 = '0;
  logic          en2, we2, regce2;
  logic [AW-1:0] addr2;
  logic [W-1:0]  dout2 = '0;
  logic          m_valid2, m_ready2, m_last2, busy2;
  logic [W-1:0]  m_data2;

  logic          cmd_valid1 = 1'b0;
  logic          cmd_ready1;
  logic [AW-1:0] cmd_addr1 = '0;
  logic [AW:0]   cmd_len1 = '0;
  logic          en1, we1, regce1;
  logic [AW-1:0] addr1;
  logic [W-1:0]  dout1 = '0;
  logic          m_valid1, m_last1, busy1;
  logic          m_ready1 = 1'b1;
  logic [W-1:0]  m_data1;

  bram_rd_streamer #(
    .RAM_WIDTH(W), .RAM_DEPTH(DEP), .RD_LATENCY(2)
  ) dut2 (
    .clka(clk), .rst(rst),
    .cmd_valid(cmd_valid2), .cmd_ready(cmd_ready2),
    .cmd_addr(cmd_addr2), .cmd_len(cmd_len2),
    .bram_en(en2), .bram_we(we2), .bram_regce(regce2),
    .bram_addr(addr2), .bram_dout(dout2),
    .m_valid(m_valid2), .m_ready(m_ready2),
    .m_data(m_data2), .m_last(m_last2), .busy(busy2)
  );

  bram_rd_streamer #(
    .RAM_WIDTH(W), .RAM_DEPTH(DEP), .RD_LATENCY(1)
  ) dut1 (
    .clka(clk), .rst(rst),
    .cmd_valid(cmd_valid1), .cmd_ready(cmd_ready1),
    .cmd_addr(cmd_addr1), .cmd_len(cmd_len1),
    .bram_en(en1), .bram_we(we1), .bram_regce(regce1),
    .bram_addr(addr1), .bram_dout(dout1),
    .m_valid(m_valid1), .m_ready(m_ready1),
    .m_data(m_data1), .m_last(m_last1), .busy(busy1)
  );

  // BRAM contents: word i holds i.
  logic [W-1:0] r1q = '0;
  always @(posedge clk) begin
    if (en2)    r1q   <= W'(addr2);
    if (regce2) dout2 <= r1q;
    if (en1)    dout1 <= W'(addr1);
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)",
               nm, act, exp, $time);
    end
  endtask

  // reference model state
  int           qa[$];
  logic [W:0]   qd[$];
  int           issued = 0;
  int           popped = 0;
  bit           want_first = 0;
  bit           want_fbeat = 0;
  bit           done = 0;
  int           first_cyc = 0;
  int           final_cyc = 0;
  logic [W-1:0] first_d = '0;
  logic [W-1:0] final_d = '0;

  // backpressure pattern: 0 = always ready, 1 = 1,0,0 repeating, 2 = random
  int mode = 0;
  int ph = 0;
  initial begin
    m_ready2 = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      ph++;
      case (mode)
        0:       m_ready2 = 1'b1;
        1:       m_ready2 = (ph % 3 == 0);
        default: m_ready2 = 1'($urandom % 2);
      endcase
    end
  end

  // stream monitor for the latency-2 instance
  initial begin
    bit         stall_q;
    logic [W:0] stall_v;
    logic [W:0] e;
    stall_q = 0;
    stall_v = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stall_q = 0;
      end else begin
        if (en2) begin
          issued++;
          chk("bram_we", 32'(we2), 0);
          if (qa.size() == 0) chk("unexpected_issue", 1, 0);
          else chk("bram_addr", 32'(addr2), qa.pop_front());
        end
        if (m_valid2 && want_first) begin
          first_cyc  = cyc;
          want_first = 0;
        end
        if (stall_q) begin
          chk("stall_valid", 32'(m_valid2), 1);
          chk("stall_word", 32'({m_last2, m_data2}), 32'(stall_v));
        end
        stall_q = m_valid2 && !m_ready2;
        stall_v = {m_last2, m_data2};
        if (m_valid2 && m_ready2) begin
          popped++;
          if (qd.size() == 0) begin
            chk("unexpected_beat", 1, 0);
          end else begin
            e = qd.pop_front();
            chk("beat", 32'({m_last2, m_data2}), 32'(e));
            if (want_fbeat) begin
              first_d    = m_data2;
              want_fbeat = 0;
            end
            if (e[W]) begin
              final_d   = m_data2;
              final_cyc = cyc;
              done      = 1;
            end
          end
        end
        chk("credit", 32'(issued - popped <= D2), 1);
      end
    end
  end

  task automatic launch(input int a, input int l, output int t0);
    int b;
    @(negedge clk);
    cmd_valid2 = 1'b1;
    cmd_addr2  = AW'(a);
    cmd_len2   = (AW+1)'(l);
    b = 0;
    while (!cmd_ready2 && b < 100) begin
      @(negedge clk);
      b++;
    end
    if (!cmd_ready2) chk("cmd_ready_wait", 0, 1);
    for (int i = 0; i < l; i++) begin
      qa.push_back((a + i) % DEP);
      qd.push_back({(i == l - 1), W'((a + i) % DEP)});
    end
    done       = 0;
    want_first = (l != 0);
    want_fbeat = (l != 0);
    t0 = cyc;
    @(posedge clk);
    #1 cmd_valid2 = 1'b0;
  endtask

  task automatic run_cmd(input int a, input int l, input int md,
                         output int lat);
    int b, t0;
    mode = md;
    launch(a, l, t0);
    b = 0;
    while (!done && b < 5000) begin
      @(posedge clk);
      #2;
      b++;
    end
    if (!done) begin
      chk("timeout", 0, 1);
    end else begin
      chk("busy_drop", 32'(busy2), 0);
      chk("cmd_ready_back", 32'(cmd_ready2), 1);
    end
    lat = first_cyc - t0;
  endtask

  typedef struct {
    int addr;
    int len;
    int md;
    int exp_lat;
    int exp_first;
    int exp_final;
  } vec_t;

  vec_t tv[5];

  initial begin
    int lat, t0, a, l;
    tv[0] = '{5,    4,    0, 3, 5,    8};
    tv[1] = '{1022, 4,    0, 3, 1022, 1};
    tv[2] = '{0,    16,   1, 3, 0,    15};
    tv[3] = '{300,  1,    1, 3, 300,  300};
    tv[4] = '{1020, 1030, 0, 3, 1020, 1};

    rst = 1'b1;
    #2;
    chk("rst_cmd_ready", 32'(cmd_ready2), 1);
    chk("rst_outs", 32'({en2, we2, regce2, m_valid2,
                          m_last2, busy2}), 0);
    chk("rst_addr", 32'(addr2), 0);
    chk("rst_data", 32'(m_data2), 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;

    for (int i = 0; i < 5; i++) begin
      run_cmd(tv[i].addr, tv[i].len, tv[i].md, lat);
      chk("latency", 32'(lat), 32'(tv[i].exp_lat));
      chk("first_word", 32'(first_d), 32'(tv[i].exp_first));
      chk("final_word", 32'(final_d), 32'(tv[i].exp_final));
      if (tv[i].md == 0)
        chk("back_to_back", 32'(final_cyc - first_cyc),
            32'(tv[i].len - 1));
    end

    // empty command
    mode = 0;
    @(negedge clk);
    cmd_valid2 = 1'b1;
    cmd_addr2  = 10'd9;
    cmd_len2   = '0;
    chk("len0_ready", 32'(cmd_ready2), 1);
    @(posedge clk);
    #1 cmd_valid2 = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #2;
      chk("len0_quiet", 32'({en2, m_valid2, busy2}), 0);
      chk("len0_ready_hold", 32'(cmd_ready2), 1);
    end

    // reset with two reads in flight
    launch(40, 8, t0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_ready", 32'(cmd_ready2), 1);
    chk("mid_rst_outs", 32'({en2, regce2, m_valid2,
                              m_last2, busy2}), 0);
    chk("mid_rst_data", 32'(m_data2), 0);
    chk("mid_rst_addr", 32'(addr2), 0);
    qa.delete();
    qd.delete();
    issued = 0;
    popped = 0;
    want_first = 0;
    want_fbeat = 0;
    done = 0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    repeat (4) @(posedge clk);
    run_cmd(77, 5, 0, lat);
    chk("post_rst_lat", 32'(lat), 3);
    chk("post_rst_first", 32'(first_d), 77);
    chk("post_rst_final", 32'(final_d), 81);

    // latency-1 port: words at accept+2, +3, +4
    @(negedge clk);
    cmd_valid1 = 1'b1;
    cmd_addr1  = 10'd7;
    cmd_len1   = 11'd3;
    chk("l1_ready", 32'(cmd_ready1), 1);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      cmd_valid1 = 1'b0;
      chk("l1_valid", 32'(m_valid1), 32'(k >= 2 && k <= 4));
      if (k >= 2 && k <= 4) begin
        chk("l1_data", 32'(m_data1), 32'(7 + k - 2));
        chk("l1_last", 32'(m_last1), 32'(k == 4));
      end
    end
    chk("l1_idle", 32'(busy1), 0);

    // random commands under random backpressure
    for (int n = 0; n < 25; n++) begin
      a = (n % 4 == 0) ? DEP - 1 - int'($urandom % 4)
                       : int'($urandom % DEP);
      l = 1 + int'($urandom % 40);
      run_cmd(a, l, 2, lat);
      chk("rand_lat", 32'(lat), 3);
      chk("rand_final", 32'(final_d), 32'((a + l - 1) % DEP));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
